clcd_seq: RTL
=============

# clcd_seq

Character-LCD write sequencer for the host interface's CLCD port. Instead of the host bit-banging RS/RW/E/DQ through a register, the host pushes 9-bit entries into a 16-deep FIFO. Each entry is bit 8 = RS and bits 7:0 = data/command. The block generates HD44780-compliant write cycles and waits out each instruction's execution time. After reset it runs the power-on wait and the init sequence by itself, so software never polls the LCD busy flag.

## Interface
- T_AS, 3: address setup cycles (RS/DQ valid before E rises)
- T_PW, 13: E-high pulse width, cycles
- T_H, 2: hold cycles after E falls
- T_CMD, 2000: execution wait, normal entries (40 µs @ 50 MHz)
- T_CLR, 82000: execution wait, RS=0 with data 0x01, 0x02 or 0x03 (clear/home)
- T_PWRON, 750000: post-reset wait before init (15 ms)
- DEPTH, 16: FIFO depth, power of two
- clk  in  1  system clock, 50 MHz
- nRESET  in  1  reset, asynchronous, active-low
- wr_en  in  1  one-cycle push strobe
- wr_data  in  9  {RS, DQ[7:0]}
- init_req  in  1  one-cycle request to re-run the init sequence
- ovf_clr  in  1  clears ovf
- CLCD_RS  out  1  LCD register select
- CLCD_RW  out  1  tied 0 (write-only)
- CLCD_E  out  1  LCD enable
- CLCD_DQ  out  8  LCD data
- fifo_count  out  5  entries held, 0..DEPTH
- fifo_full  out  1  fifo_count == DEPTH
- busy  out  1  state != IDLE or fifo_count != 0 or init pending
- ovf  out  1  sticky: a push was dropped

## Operation
- All outputs are registered.
- Reset values:
  - CLCD_RS = 0, CLCD_RW = 0, CLCD_E = 0, CLCD_DQ = 0x00
  - fifo_count = 0, fifo_full = 0, ovf = 0, busy = 1
  - state = PWRUP
- Assertion of nRESET aborts any cycle in progress: E drops immediately, the FIFO empties, and the init-pending flag clears.
- States:
  - PWRUP: wait T_PWRON cycles, then go to INIT with ROM index 0.
  - INIT: load ROM[idx] as a command (RS=0) and go to SETUP. The ROM holds 0x38, 0x0C, 0x06, 0x01. After the 4th entry's WAIT completes, go to IDLE.
  - IDLE:
    - If init is pending: clear the flag, idx = 0, go to INIT.
    - Else if fifo_count > 0: pop the head, drive RS/DQ from it, go to SETUP.
  - SETUP: E = 0 for T_AS cycles, then PULSE.
  - PULSE: E = 1 for T_PW cycles, then HOLD.
  - HOLD: E = 0 for T_H cycles, then WAIT.
  - WAIT: count T_CLR if the entry has RS=0 and DQ ∈ {0x01, 0x02, 0x03}; otherwise count T_CMD. At the end, apply the IDLE decision in the same cycle (next INIT entry, init, pop, or IDLE). Back-to-back entries therefore need no idle cycle.
- RS/DQ stay stable from SETUP entry until the next entry is loaded. DQ is never changed while E = 1.
- FIFO:
  - A push is accepted when wr_en = 1 and fifo_count < DEPTH, evaluated before any same-cycle pop.
  - A push when full is dropped and sets ovf, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - Order is strictly FIFO.
- Pushes are accepted in every state, including PWRUP and INIT.
- init_req:
  - Sets the pending flag, which is serviced at the next IDLE decision point.
  - FIFO contents are preserved and drained after the init sequence.
  - A second init_req while one is already pending has no additional effect.
- ovf_clr clears ovf. If ovf_clr and an overflowing push occur in the same cycle, ovf = 1 (set wins).

## Timing
- Push latency: wr_en sampled at edge k gives fifo_count +1 after edge k.
- Start latency, with an empty FIFO and state IDLE:
  - Pop happens at edge k+1, and RS/DQ are valid after edge k+1.
  - E rises after edge k+1+T_AS.
  - E falls after edge k+1+T_AS+T_PW.
- Entry period: SETUP-to-SETUP for consecutive entries is T_AS+T_PW+T_H+T_exec cycles.
- E-high width is exactly T_PW cycles.
- Counters are 20 bits wide; every parameter must be ≥ 1.
- PWRUP lasts T_PWRON cycles from reset release. The first E rise for ROM[0] occurs T_PWRON+1+T_AS cycles after reset release.

## Test plan
Simulation parameters for all scenarios: T_AS=2, T_PW=4, T_H=1, T_CMD=10, T_CLR=40, T_PWRON=20.

1. Reset release, no pushes:
   - E pulses four times with DQ = 0x38, 0x0C, 0x06, 0x01 and RS = 0.
   - Each E-high lasts 4 cycles; the gap after 0x01 is 40 wait cycles.
   - busy falls after the last WAIT.
2. After init, push 0x141 then 0x142:
   - First E rise 3 cycles after the push (1-cycle pop plus T_AS = 2).
   - Both entries go out with RS = 1, DQ 0x41 then 0x42.
   - E rises are 17 cycles apart (2+4+1+10).
3. 18 pushes during PWRUP:
   - fifo_count saturates at 16 and ovf = 1.
   - The 17th and 18th entries never appear on DQ.
   - ovf_clr returns ovf to 0.
4. Push 0x001 then 0x020:
   - WAIT after 0x01 lasts 40 cycles; WAIT after 0x20 lasts 10 cycles.
5. init_req while an entry is in PULSE, with 2 entries queued:
   - The current cycle completes.
   - The 4 ROM commands are sent, then the 2 queued entries, in that order.
6. nRESET asserted while E = 1:
   - E = 0 immediately, fifo_count = 0, busy = 1.
   - After release, scenario 1 repeats.

Source files
------------

// File: rtl/clcd_seq.sv
// Character-LCD write sequencer: 9-bit {RS,DQ} FIFO feeding HD44780 write
// cycles, with automatic power-on wait, init ROM and per-entry exec waits.
module clcd_seq #(
    parameter int unsigned T_AS    = 3,
    parameter int unsigned T_PW    = 13,
    parameter int unsigned T_H     = 2,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000,
    parameter int unsigned T_PWRON = 750000,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     nRESET,
    input  logic                     wr_en,
    input  logic [8:0]               wr_data,
    input  logic                     init_req,
    input  logic                     ovf_clr,
    output logic                     CLCD_RS,
    output logic                     CLCD_RW,
    output logic                     CLCD_E,
    output logic [7:0]               CLCD_DQ,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     busy,
    output logic                     ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [19:0] L_AS  = 20'(T_AS - 1);
    localparam logic [19:0] L_PW  = 20'(T_PW - 1);
    localparam logic [19:0] L_H   = 20'(T_H - 1);
    localparam logic [19:0] L_CMD = 20'(T_CMD - 1);
    localparam logic [19:0] L_CLR = 20'(T_CLR - 1);
    localparam logic [19:0] L_PWR = 20'(T_PWRON - 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
    } state_t;

    state_t          r_state;
    logic [19:0]     r_cnt;
    logic [2:0]      r_idx;
    logic            r_rom;
    logic            r_long;
    logic            r_pend;
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_count;
    logic            r_full;
    logic            r_ovf;
    logic            r_busy;
    logic            r_rs;
    logic            r_e;
    logic [7:0]      r_dq;
    logic [8:0]      r_mem [DEPTH];

    function automatic logic [7:0] f_rom(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    logic [19:0]   w_wait_lim;
    logic          w_dec;
    logic          w_rom_more;
    logic          w_rom_ld;
    logic          w_svc;
    logic          w_pop;
    logic          w_push;
    logic          w_ld;
    logic          w_pend_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [8:0]    w_ld_data;
    logic          w_ld_long;

    assign w_wait_lim = r_long ? L_CLR : L_CMD;
    assign w_dec      = (r_state == S_IDLE) ||
                        (r_state == S_WAIT && r_cnt == w_wait_lim);
    // An unfinished ROM sequence always outranks init requests and FIFO pops
    assign w_rom_more = r_rom && (r_idx != 3'd4);
    assign w_rom_ld   = (r_state == S_INIT) ||
                        (r_state == S_WAIT && w_dec && w_rom_more);
    assign w_svc      = w_dec && !w_rom_more && r_pend;
    assign w_pop      = w_dec && !w_rom_more && !r_pend && (r_count != '0);
    assign w_push     = wr_en && (r_count != L_DEPTH);
    assign w_ld       = w_rom_ld || w_pop;
    assign w_pend_nxt = (r_pend && !w_svc) || init_req;
    assign w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_ld_data  = w_rom_ld ? {1'b0, f_rom(r_idx[1:0])} : r_mem[r_rp];
    assign w_ld_long  = !w_ld_data[8] && (w_ld_data[7:2] == 6'd0) &&
                        (w_ld_data[1:0] != 2'd0);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= wr_data;
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_PWRUP;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rom   <= 1'b0;
            r_long  <= 1'b0;
            r_pend  <= 1'b0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
            r_dq    <= '0;
        end else begin
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == L_DEPTH);
            r_pend  <= w_pend_nxt;
            r_busy  <= 1'b1;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (wr_en && !w_push) r_ovf <= 1'b1;
            else if (ovf_clr)     r_ovf <= 1'b0;
            if (w_rom_ld) r_idx <= r_idx + 3'd1;
            if (w_ld) begin
                r_rs    <= w_ld_data[8];
                r_dq    <= w_ld_data[7:0];
                r_long  <= w_ld_long;
                r_cnt   <= '0;
                r_state <= S_SETUP;
            end else begin
                unique case (r_state)
                    S_PWRUP: begin
                        if (r_cnt == L_PWR) begin
                            r_state <= S_INIT;
                            r_rom   <= 1'b1;
                            r_idx   <= '0;
                            r_cnt   <= '0;
                        end else r_cnt <= r_cnt + 20'd1;
                    end
                    S_SETUP: begin
                        if (r_cnt == L_AS) begin
                            r_state <= S_PULSE;
                            r_e     <= 1'b1;
                            r_cnt   <= '0;
                        end else r_cnt <= r_cnt + 20'd1;
                    end
                    S_PULSE: begin
                        if (r_cnt == L_PW) begin
                            r_state <= S_HOLD;
                            r_e     <= 1'b0;
                            r_cnt   <= '0;
                        end else r_cnt <= r_cnt + 20'd1;
                    end
                    S_HOLD: begin
                        if (r_cnt == L_H) begin
                            r_state <= S_WAIT;
                            r_cnt   <= '0;
                        end else r_cnt <= r_cnt + 20'd1;
                    end
                    S_IDLE, S_WAIT: begin
                        if (!w_dec) begin
                            r_cnt <= r_cnt + 20'd1;
                        end else if (w_svc) begin
                            r_state <= S_INIT;
                            r_rom   <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= (w_cnt_nxt != '0) || w_pend_nxt;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign CLCD_RS    = r_rs;
    assign CLCD_RW    = 1'b0;
    assign CLCD_E     = r_e;
    assign CLCD_DQ    = r_dq;
    assign fifo_count = r_count;
    assign fifo_full  = r_full;
    assign busy       = r_busy;
    assign ovf        = r_ovf;
endmodule
